// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared encodings for the byte-serial load/store sequencer: access sizes,
// FSM states and bus widths.
package lsu_byte_sequencer_pkg;

  localparam int ADDR_BUS_WIDTH     = 32;
  localparam int MEM_DATA_BUS_WIDTH = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Index of the last byte lane touched by an access of the given size.
  function automatic logic [1:0] last_byte_idx(input size_e size);
    case (size)
      SIZE_BYTE: last_byte_idx = 2'd0;
      SIZE_HALF: last_byte_idx = 2'd1;
      SIZE_WORD: last_byte_idx = 2'd3;
      default:   last_byte_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational zero/sign extension of assembled load bytes to a full word.
import lsu_byte_sequencer_pkg::*;

module lsu_load_extend #(
  parameter int BYTE_W = MEM_DATA_BUS_WIDTH,
  parameter int WORD_W = 4 * MEM_DATA_BUS_WIDTH
) (
  input  logic [WORD_W-1:0] cap_data,
  input  size_e             size,
  input  logic              sign_en,
  output logic [WORD_W-1:0] ext_data
);

  // Replicate the top bit of the accessed bytes when signed, else zero-fill.
  always_comb begin
    ext_data = cap_data;
    case (size)
      SIZE_BYTE: ext_data = {{(WORD_W-BYTE_W){sign_en & cap_data[BYTE_W-1]}},
                             cap_data[BYTE_W-1:0]};
      SIZE_HALF: ext_data = {{(WORD_W-2*BYTE_W){sign_en & cap_data[2*BYTE_W-1]}},
                             cap_data[2*BYTE_W-1:0]};
      default:   ext_data = cap_data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits word/half/byte loads and stores into little-endian byte accesses.
// Optional build macro LSU_ALIGN_CHECK_EN rejects misaligned half/word requests.
import lsu_byte_sequencer_pkg::*;

module lsu_byte_sequencer #(
  parameter int ADDR_W = ADDR_BUS_WIDTH,
  parameter int BYTE_W = MEM_DATA_BUS_WIDTH,
  parameter int WORD_W = 4 * MEM_DATA_BUS_WIDTH
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [WORD_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [BYTE_W-1:0] mem_wd,
  input  logic [BYTE_W-1:0] mem_rd,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  state_e              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  size_e               size_r;
  logic                signed_r;
  logic [WORD_W-1:0]   wdata_r;
  logic [1:0]          k_r;
  logic [WORD_W-1:0]   cap_r, cap_nxt_s, ext_s;
  logic                resp_valid_r, resp_err_r;
  logic [WORD_W-1:0]   resp_rdata_r;
  logic                req_err_s;
  logic [1:0]          last_k_s;

  assign last_k_s = last_byte_idx(size_r);

  // Decide whether an incoming request is rejected without touching memory.
  always_comb begin
    req_err_s = (req_size == SIZE_RSVD);
`ifdef LSU_ALIGN_CHECK_EN
    if (req_size == SIZE_HALF && req_addr[0] != 1'b0) begin
      req_err_s = 1'b1;
    end else if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = req_err_s;
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) state_nxt_s = req_err_s ? ST_RESP : ST_ACCESS;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (k_r == last_k_s) state_nxt_s = ST_RESP;
        else                 state_nxt_s = ST_ACCESS;
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Merge this cycle's read byte so the final lane reaches the response register.
  always_comb begin
    cap_nxt_s = cap_r;
    cap_nxt_s[int'(k_r)*BYTE_W +: BYTE_W] = mem_rd;
  end

  lsu_load_extend #(.BYTE_W(BYTE_W), .WORD_W(WORD_W)) u_extend (
    .cap_data (cap_nxt_s),
    .size     (size_r),
    .sign_en  (signed_r),
    .ext_data (ext_s)
  );

  // Request capture, byte counter, load capture and registered response.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      addr_r       <= {ADDR_W{1'b0}};
      we_r         <= 1'b0;
      size_r       <= SIZE_BYTE;
      signed_r     <= 1'b0;
      wdata_r      <= {WORD_W{1'b0}};
      k_r          <= 2'd0;
      cap_r        <= {WORD_W{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            addr_r       <= req_addr;
            we_r         <= req_we;
            size_r       <= size_e'(req_size);
            signed_r     <= req_signed;
            wdata_r      <= req_wdata;
            k_r          <= 2'd0;
            cap_r        <= {WORD_W{1'b0}};
            resp_valid_r <= req_err_s;
            resp_err_r   <= req_err_s;
            resp_rdata_r <= {WORD_W{1'b0}};
          end
        end
        ST_ACCESS: begin
          if (!we_r) cap_r <= cap_nxt_s;
          if (k_r == last_k_s) begin
            k_r          <= 2'd0;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= we_r ? {WORD_W{1'b0}} : ext_s;
          end else begin
            k_r <= k_r + 2'd1;
          end
        end
        ST_RESP: begin
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {WORD_W{1'b0}};
        end
        default: begin
          k_r          <= 2'd0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= {WORD_W{1'b0}};
        end
      endcase
    end
  end

  // Memory port is driven only while bytes are being transferred.
  always_comb begin
    if (state_r == ST_ACCESS) begin
      mem_addr = addr_r + {{(ADDR_W-2){1'b0}}, k_r};
      mem_we   = we_r;
      mem_wd   = wdata_r[int'(k_r)*BYTE_W +: BYTE_W];
    end else begin
      mem_addr = {ADDR_W{1'b0}};
      mem_we   = 1'b0;
      mem_wd   = {BYTE_W{1'b0}};
    end
  end

  assign req_ready  = (state_r == ST_IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed self-checking bench for lsu_byte_sequencer with a 256-byte memory model.
module tb_lsu_byte_sequencer;

  logic        clk_in, reset_in;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd, mem_rd;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic [7:0]  mem [0:255];
  logic        mem_clr;

  int          checks, failures;
  logic [31:0] addr_log [0:7];
  int          n_log, lat;
  logic        we_seen, got, r_err, no_resp;
  logic [31:0] r_rdata;

  lsu_byte_sequencer dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  assign mem_rd = mem[mem_addr[7:0]];

  always @(posedge clk_in) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd);
    @(negedge clk_in);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz;
    req_signed = sg; req_wdata = wd;
    @(posedge clk_in);
    #1;
    req_valid = 1'b0;
    n_log = 0; we_seen = 1'b0; got = 1'b0; lat = 0;
    r_rdata = 32'h0; r_err = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk_in);
      if (mem_we) we_seen = 1'b1;
      if (!req_ready && !resp_valid && n_log < 8) begin
        addr_log[n_log] = mem_addr;
        n_log++;
      end
      if (resp_valid) begin
        got = 1'b1; lat = c; r_rdata = resp_rdata; r_err = resp_err;
      end
    end
    check("resp_seen", {31'd0, got}, 32'd1);
    @(negedge clk_in);
    check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    check("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_in = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = 32'h0;
    repeat (3) @(negedge clk_in);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", {24'd0, mem_wd}, 32'h0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    reset_in = 1'b0; mem_clr = 1'b0;

    // Word store then word load
    do_req(32'h10, 1'b1, 2'b10, 1'b0, 32'h11223344);
    check("wst_lat", lat, 32'd5);
    check("wst_err", {31'd0, r_err}, 32'd0);
    check("wst_rdata", r_rdata, 32'h0);
    check("wst_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h11223344);
    check("wst_addr_first", addr_log[0], 32'h10);
    check("wst_addr_last", addr_log[3], 32'h13);
    do_req(32'h10, 1'b0, 2'b10, 1'b1, 32'h0);
    check("wld_lat", lat, 32'd5);
    check("wld_rdata", r_rdata, 32'h11223344);

    // Byte and halfword preload via stores, then extended loads
    do_req(32'h20, 1'b1, 2'b00, 1'b0, 32'hFFFFFF80);
    check("bst_lat", lat, 32'd2);
    check("bst_mem", {24'd0, mem[8'h20]}, 32'h80);
    check("bst_neighbour", {24'd0, mem[8'h21]}, 32'h00);
    do_req(32'h20, 1'b0, 2'b00, 1'b1, 32'h0);
    check("bld_s_rdata", r_rdata, 32'hFFFFFF80);
    check("bld_s_lat", lat, 32'd2);
    do_req(32'h20, 1'b0, 2'b00, 1'b0, 32'h0);
    check("bld_u_rdata", r_rdata, 32'h00000080);
    do_req(32'h30, 1'b1, 2'b01, 1'b0, 32'h12348001);
    check("hst_mem", {16'd0, mem[8'h31], mem[8'h30]}, 32'h8001);
    do_req(32'h30, 1'b0, 2'b01, 1'b1, 32'h0);
    check("hld_s_rdata", r_rdata, 32'hFFFF8001);
    check("hld_s_lat", lat, 32'd3);
    do_req(32'h30, 1'b0, 2'b01, 1'b0, 32'h0);
    check("hld_u_rdata", r_rdata, 32'h00008001);

    // Reserved size is always rejected
    do_req(32'h44, 1'b1, 2'b11, 1'b0, 32'hCAFEF00D);
    check("rsvd_err", {31'd0, r_err}, 32'd1);
    check("rsvd_lat", lat, 32'd1);
    check("rsvd_no_we", {31'd0, we_seen}, 32'd0);
    check("rsvd_rdata", r_rdata, 32'h0);
    check("rsvd_mem", {24'd0, mem[8'h44]}, 32'h00);

    // Misaligned halfword load
    do_req(32'h21, 1'b1, 2'b00, 1'b0, 32'h0000005A);
    do_req(32'h22, 1'b1, 2'b00, 1'b0, 32'h000000C3);
    do_req(32'h21, 1'b0, 2'b01, 1'b1, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    check("unal_err", {31'd0, r_err}, 32'd1);
    check("unal_lat", lat, 32'd1);
    check("unal_rdata", r_rdata, 32'h0);
`else
    check("unal_err", {31'd0, r_err}, 32'd0);
    check("unal_lat", lat, 32'd3);
    check("unal_rdata", r_rdata, 32'hFFFFC35A);
`endif

    // Word access wrapping the top of the address space
    do_req(32'hFFFFFFFE, 1'b1, 2'b10, 1'b0, 32'hA1B2C3D4);
`ifdef LSU_ALIGN_CHECK_EN
    check("wrap_err", {31'd0, r_err}, 32'd1);
    check("wrap_no_we", {31'd0, we_seen}, 32'd0);
`else
    check("wrap_err", {31'd0, r_err}, 32'd0);
    check("wrap_addr0", addr_log[0], 32'hFFFFFFFE);
    check("wrap_addr1", addr_log[1], 32'hFFFFFFFF);
    check("wrap_addr2", addr_log[2], 32'h00000000);
    check("wrap_addr3", addr_log[3], 32'h00000001);
    check("wrap_mem", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}, 32'hA1B2C3D4);
    do_req(32'hFFFFFFFE, 1'b0, 2'b10, 1'b0, 32'h0);
    check("wrap_load", r_rdata, 32'hA1B2C3D4);
`endif

    // Reset during the second byte of a word store
    @(negedge clk_in);
    req_valid = 1'b1; req_addr = 32'h50; req_we = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_wdata = 32'hDEADBEEF;
    @(posedge clk_in);
    #1;
    req_valid = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    check("abort_byte1_active", mem_addr, 32'h51);
    reset_in = 1'b1;
    #1;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wd", {24'd0, mem_wd}, 32'h0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    no_resp = 1'b1;
    repeat (6) begin
      @(negedge clk_in);
      if (resp_valid) no_resp = 1'b0;
    end
    check("abort_no_resp", {31'd0, no_resp}, 32'd1);
    check("abort_mem", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h000000EF);
    do_req(32'h50, 1'b0, 2'b10, 1'b0, 32'h0);
    check("post_abort_lat", lat, 32'd5);
    check("post_abort_rdata", r_rdata, 32'h000000EF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
